// File: rtl/btn_event_queue.sv
// btn_event_queue: priority-arbitrated press pending register feeding a
// first-word-fall-through FIFO of button codes with a sticky loss flag.
module btn_event_queue #(
    parameter int unsigned NUM_BTN = 4,
    parameter int unsigned CODE_W  = 2,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned CNT_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_pulse,
    output logic [CODE_W-1:0]  evt_code,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [CNT_W-1:0]   count,
    output logic               overflow,
    input  logic               clr_overflow
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [NUM_BTN-1:0] pend;
    logic [NUM_BTN-1:0] grant;
    logic [NUM_BTN-1:0] lost;
    logic [CODE_W-1:0]  grant_idx;
    logic [CODE_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               has_room;
    logic               push;
    logic               pop;

    // Head of queue is visible while non-empty; count alone tracks full/empty.
    assign evt_valid = (count != '0);
    assign evt_code  = mem[rd_ptr];

    // Lowest-index pending press wins while the FIFO has room (pre-edge count).
    always_comb begin
        has_room  = (count < CNT_W'(DEPTH));
        grant     = '0;
        grant_idx = '0;
        if (has_room) begin
            grant = pend & (~pend + NUM_BTN'(1));
        end
        for (int unsigned i = 0; i < NUM_BTN; i++) begin
            if (grant[i]) begin
                grant_idx = CODE_W'(i);
            end
        end
        push = |grant;
        pop  = evt_valid && evt_ready;
        lost = btn_pulse & pend & ~grant;
    end

    // Pending presses: granted bit clears, new pulses (re)set their bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            pend <= (pend & ~grant) | btn_pulse;
        end
    end

    // FIFO storage and write pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
        end else if (push) begin
            mem[wr_ptr] <= grant_idx;
            wr_ptr      <= wr_ptr + PTR_W'(1);
        end
    end

    // Read pointer advances on an accepted head entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
        end else if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // Occupancy count: simultaneous push and pop cancel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (push && !pop) begin
            count <= count + CNT_W'(1);
        end else if (pop && !push) begin
            count <= count - CNT_W'(1);
        end
    end

    // Sticky loss flag; a loss in the clearing cycle keeps it set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (|lost) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

endmodule
